// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor d = a - b - bin, LSB first, one bit per clock.
// A single full-subtractor cell works through the operand bits. The borrow between
// bits is held in a register.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rr;
    logic             br;
    logic [CNT_W-1:0] cnt;

    logic             x;
    logic             br_nxt;
    logic             last;

    // One full-subtractor cell: returns {borrow_out, difference}.
    function automatic logic [1:0] fsub_cell(input logic ai, input logic bi, input logic bri);
        logic diff;
        logic bout;
        diff = ai ^ bi ^ bri;
        bout = (~ai & bi) | (~(ai ^ bi) & bri);
        return {bout, diff};
    endfunction

    // Current bit of the subtraction and detection of the final bit.
    always_comb begin
        {br_nxt, x} = fsub_cell(ra[0], rb[0], br);
        last        = (cnt == CNT_W'(WIDTH - 1));
    end

    // Next-state logic and status outputs decoded from the state.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Operand load, per-bit shift, and result capture on the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ra  <= '0;
            rb  <= '0;
            rr  <= '0;
            br  <= 1'b0;
            cnt <= '0;
            d   <= '0;
            bo  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        ra  <= a;
                        rb  <= b;
                        br  <= bin;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    ra <= ra >> 1;
                    rb <= rb >> 1;
                    rr <= {x, rr[WIDTH-1:1]};
                    br <= br_nxt;
                    // The counter parks on the last index so it never wraps mid-operation.
                    if (!last) cnt <= cnt + 1'b1;
                    if (last) begin
                        d  <= {x, rr[WIDTH-1:1]};
                        bo <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
                        // Borrow into the MSB differs from borrow out of it on signed overflow.
                        ovf <= br ^ br_nxt;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
